// File: rtl/nonce_search_pkg.sv
// rtl/nonce_search_pkg.sv - shared types, default widths and block sizing for the nonce search engine
package nonce_search_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int DEF_HEADER_BYTES = 12;
    localparam int DEF_NONCE_BYTES  = 4;
    localparam int DEF_HASH_BYTES   = 3;
    localparam int DEF_TARGET_BYTES = 1;
    localparam int DEF_TIMEOUT      = 64;

    function automatic int block_bytes(input int header_bytes, input int nonce_bytes);
        return header_bytes + nonce_bytes;
    endfunction

endpackage

// File: rtl/block_concat.sv
// rtl/block_concat.sv - forms the hash input block {header, nonce}, header in the high bytes
module block_concat
    import nonce_search_pkg::*;
#(
    parameter int HEADER_BYTES = DEF_HEADER_BYTES,
    parameter int NONCE_BYTES  = DEF_NONCE_BYTES
) (
    input  logic [HEADER_BYTES-1:0][7:0]                          header,
    input  logic [NONCE_BYTES-1:0][7:0]                           nonce,
    output logic [block_bytes(HEADER_BYTES, NONCE_BYTES)-1:0][7:0] block
);

    assign block = {header, nonce};

endmodule

// File: rtl/nonce_search_engine.sv
// rtl/nonce_search_engine.sv - walks a nonce range through an external hash core until a hash beats the target
module nonce_search_engine
    import nonce_search_pkg::*;
#(
    parameter int HEADER_BYTES = DEF_HEADER_BYTES,
    parameter int NONCE_BYTES  = DEF_NONCE_BYTES,
    parameter int HASH_BYTES   = DEF_HASH_BYTES,
    parameter int TARGET_BYTES = DEF_TARGET_BYTES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [HEADER_BYTES-1:0][7:0]              header,
    input  logic [NONCE_BYTES-1:0][7:0]               nonce_start,
    input  logic [NONCE_BYTES-1:0][7:0]               nonce_limit,
    input  logic [TARGET_BYTES-1:0][7:0]              target,
    output logic                                      hash_start,
    output logic [HEADER_BYTES+NONCE_BYTES-1:0][7:0]  hash_block,
    input  logic                                      hash_done,
    input  logic [HASH_BYTES-1:0][7:0]                hash_out,
    output logic                                      busy,
    output logic                                      found,
    output logic                                      exhausted,
    output logic                                      timeout_err,
    output logic [NONCE_BYTES-1:0][7:0]               nonce_out,
    output logic [HASH_BYTES-1:0][7:0]                hash_result,
    output logic [NONCE_BYTES*8:0]                    attempts
);

    localparam int NW = NONCE_BYTES * 8;
    localparam int AW = NONCE_BYTES * 8 + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t                        state_q, state_d;
    logic [HEADER_BYTES-1:0][7:0]  header_q, header_d;
    logic [NONCE_BYTES-1:0][7:0]   nonce_q, nonce_d;
    logic [NONCE_BYTES-1:0][7:0]   limit_q, limit_d;
    logic [TARGET_BYTES-1:0][7:0]  target_q, target_d;
    logic [HASH_BYTES-1:0][7:0]    hash_result_q, hash_result_d;
    logic [AW-1:0]                 attempts_q, attempts_d;
    logic [WW-1:0]                 wait_cnt_q, wait_cnt_d;
    logic                          hash_start_q, hash_start_d;
    logic                          busy_q, busy_d;
    logic                          found_q, found_d;
    logic                          exhausted_q, exhausted_d;
    logic                          timeout_q, timeout_d;
    logic [TARGET_BYTES*8-1:0]     hash_msb;

    // Only the most-significant TARGET_BYTES of the hash take part in the threshold test.
    assign hash_msb = hash_result_q[HASH_BYTES-1 -: TARGET_BYTES];

    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        nonce_d       = nonce_q;
        limit_d       = limit_q;
        target_d      = target_q;
        hash_result_d = hash_result_q;
        attempts_d    = attempts_q;
        wait_cnt_d    = wait_cnt_q;
        hash_start_d  = 1'b0;
        busy_d        = busy_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        timeout_d     = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    header_d      = header;
                    nonce_d       = nonce_start;
                    limit_d       = nonce_limit;
                    target_d      = target;
                    hash_result_d = '0;
                    attempts_d    = '0;
                    found_d       = 1'b0;
                    timeout_d     = 1'b0;
                    if (nonce_start > nonce_limit) begin
                        exhausted_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_DONE;
                    end else begin
                        exhausted_d  = 1'b0;
                        busy_d       = 1'b1;
                        hash_start_d = 1'b1;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (hash_done) begin
                    hash_result_d = hash_out;
                    attempts_d    = attempts_q + AW'(1);
                    state_d       = S_CHECK;
                end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_CHECK: begin
                if (hash_msb < target_q) begin
                    found_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (nonce_q == limit_q) begin
                    // Stopping here, before the increment, is what keeps an all-ones limit from wrapping.
                    exhausted_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    nonce_d      = nonce_q + NW'(1);
                    hash_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            header_q      <= '0;
            nonce_q       <= '0;
            limit_q       <= '0;
            target_q      <= '0;
            hash_result_q <= '0;
            attempts_q    <= '0;
            wait_cnt_q    <= '0;
            hash_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            nonce_q       <= nonce_d;
            limit_q       <= limit_d;
            target_q      <= target_d;
            hash_result_q <= hash_result_d;
            attempts_q    <= attempts_d;
            wait_cnt_q    <= wait_cnt_d;
            hash_start_q  <= hash_start_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            timeout_q     <= timeout_d;
        end
    end

    block_concat #(
        .HEADER_BYTES(HEADER_BYTES),
        .NONCE_BYTES (NONCE_BYTES)
    ) u_block_concat (
        .header(header_q),
        .nonce (nonce_q),
        .block (hash_block)
    );

    assign hash_start  = hash_start_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign timeout_err = timeout_q;
    assign nonce_out   = nonce_q;
    assign hash_result = hash_result_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_nonce_search_engine.sv
// tb/tb_nonce_search_engine.sv - directed bench with a latency-5 hash model for nonce_search_engine
module tb_nonce_search_engine;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [11:0][7:0]  header;
    logic [3:0][7:0]   nonce_start;
    logic [3:0][7:0]   nonce_limit;
    logic [0:0][7:0]   target;
    logic              hash_start;
    logic [15:0][7:0]  hash_block;
    logic              hash_done;
    logic [2:0][7:0]   hash_out;
    logic              busy;
    logic              found;
    logic              exhausted;
    logic              timeout_err;
    logic [3:0][7:0]   nonce_out;
    logic [2:0][7:0]   hash_result;
    logic [32:0]       attempts;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    int model_cnt = 0;
    bit model_mute = 1'b0;
    logic [7:0] model_nonce;

    nonce_search_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .header     (header),
        .nonce_start(nonce_start),
        .nonce_limit(nonce_limit),
        .target     (target),
        .hash_start (hash_start),
        .hash_block (hash_block),
        .hash_done  (hash_done),
        .hash_out   (hash_out),
        .busy       (busy),
        .found      (found),
        .exhausted  (exhausted),
        .timeout_err(timeout_err),
        .nonce_out  (nonce_out),
        .hash_result(hash_result),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    // Hash core model: hash_done lands 5 cycles after the hash_start cycle; it is not reset with the DUT.
    always @(negedge clk) begin
        hash_done = 1'b0;
        if (model_cnt > 0) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) begin
                hash_done = 1'b1;
                hash_out  = {model_nonce ^ 8'hA5, 8'h5A, model_nonce};
            end
        end
        if (hash_start) begin
            hs_count = hs_count + 1;
            if (!model_mute) begin
                model_cnt   = 5;
                model_nonce = hash_block[0];
            end
        end
    end

    task automatic do_start(input logic [31:0] ns, input logic [31:0] nl, input logic [7:0] tg);
        nonce_start = ns;
        nonce_limit = nl;
        target      = tg;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, output bit ok);
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = !busy;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({hash_start, busy, found, exhausted, timeout_err} !== 5'b0) begin
            $display("FAIL reset_flags got=%b want=00000", {hash_start, busy, found, exhausted, timeout_err});
            bad++;
        end
        total++;
        if (attempts !== 33'd0 || nonce_out !== 32'd0 || hash_result !== 24'd0) begin
            $display("FAIL reset_values got att=%0d nonce=%h hash=%h want 0/0/0", attempts, nonce_out, hash_result);
            bad++;
        end
        total++;
        if (hash_block !== 128'd0) begin
            $display("FAIL reset_block got=%h want=0", hash_block);
            bad++;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_find(input logic [7:0] tg, input logic [31:0] exp_nonce,
                             input logic [32:0] exp_att, input logic [7:0] exp_h2);
        int cyc;
        bit ok;
        do_start(32'h0, 32'hFF, tg);
        total++;
        if (hash_start !== 1'b1 || hash_block !== {header, 32'h0}) begin
            $display("FAIL find_issue got hs=%b blk=%h want hs=1 blk=%h", hash_start, hash_block, {header, 32'h0});
            bad++;
        end
        wait_idle(cyc, ok);
        total++;
        if (!ok || found !== 1'b1 || exhausted !== 1'b0 || timeout_err !== 1'b0) begin
            $display("FAIL find_status got ok=%b f=%b e=%b t=%b want 1/1/0/0", ok, found, exhausted, timeout_err);
            bad++;
        end
        total++;
        if (nonce_out !== exp_nonce || attempts !== exp_att || hash_result[2] !== exp_h2) begin
            $display("FAIL find_result got nonce=%h att=%0d h2=%h want nonce=%h att=%0d h2=%h",
                     nonce_out, attempts, hash_result[2], exp_nonce, exp_att, exp_h2);
            bad++;
        end
    endtask

    task automatic test_exhaust;
        int cyc;
        bit ok;
        do_start(32'h0, 32'h0F, 8'h03);
        repeat (10) @(posedge clk);
        #1;
        nonce_start = 32'h10;
        nonce_limit = 32'h0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(cyc, ok);
        total++;
        if (!ok || exhausted !== 1'b1 || found !== 1'b0 || attempts !== 33'd16 || nonce_out !== 32'h0F) begin
            $display("FAIL exhaust got ok=%b e=%b f=%b att=%0d nonce=%h want 1/1/0/16/0000000f",
                     ok, exhausted, found, attempts, nonce_out);
            bad++;
        end
    endtask

    task automatic test_top_of_range;
        int cyc;
        bit ok;
        int hs0;
        hs0 = hs_count;
        do_start(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00);
        wait_idle(cyc, ok);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (!ok || exhausted !== 1'b1 || found !== 1'b0 || attempts !== 33'd1 || nonce_out !== 32'hFFFFFFFF) begin
            $display("FAIL top_range got ok=%b e=%b f=%b att=%0d nonce=%h want 1/1/0/1/ffffffff",
                     ok, exhausted, found, attempts, nonce_out);
            bad++;
        end
        total++;
        if (hs_count - hs0 != 1 || busy !== 1'b0) begin
            $display("FAIL top_range_pulses got=%0d busy=%b want=1 busy=0", hs_count - hs0, busy);
            bad++;
        end
    endtask

    task automatic test_empty_range;
        int hs0;
        hs0 = hs_count;
        do_start(32'h10, 32'h0F, 8'hFF);
        total++;
        if (exhausted !== 1'b1 || busy !== 1'b0 || attempts !== 33'd0 || found !== 1'b0) begin
            $display("FAIL empty_range got e=%b busy=%b att=%0d f=%b want 1/0/0/0", exhausted, busy, attempts, found);
            bad++;
        end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (hs_count != hs0) begin
            $display("FAIL empty_range_pulses got=%0d want=0", hs_count - hs0);
            bad++;
        end
    endtask

    task automatic test_timeout;
        int n;
        bit seen_early;
        model_mute = 1'b1;
        seen_early = 1'b0;
        do_start(32'h0, 32'hFF, 8'h00);
        n = 1;
        while (n < 65) begin
            if (timeout_err !== 1'b0 || busy !== 1'b1) seen_early = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (seen_early || timeout_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL timeout_early got early=%b t=%b busy=%b at cycle 65 want 0/0/1", seen_early, timeout_err, busy);
            bad++;
        end
        @(posedge clk);
        #1;
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || attempts !== 33'd0 || found !== 1'b0 || exhausted !== 1'b0) begin
            $display("FAIL timeout_edge got t=%b busy=%b att=%0d f=%b e=%b at cycle 66 want 1/0/0/0/0",
                     timeout_err, busy, attempts, found, exhausted);
            bad++;
        end
        model_mute = 1'b0;
    endtask

    task automatic test_reset_restart;
        int cyc;
        bit ok;
        do_start(32'h0, 32'hFF, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({hash_start, busy, found, exhausted, timeout_err} !== 5'b0 || attempts !== 33'd0 || nonce_out !== 32'd0) begin
            $display("FAIL reset_mid_wait got flags=%b att=%0d nonce=%h want 0", {hash_start, busy, found, exhausted, timeout_err},
                     attempts, nonce_out);
            bad++;
        end
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (attempts !== 33'd0 || hash_result !== 24'd0 || busy !== 1'b0) begin
            $display("FAIL stray_done got att=%0d hash=%h busy=%b want 0/0/0", attempts, hash_result, busy);
            bad++;
        end
        do_start(32'h0, 32'h3, 8'h00);
        wait_idle(cyc, ok);
        total++;
        if (!ok || exhausted !== 1'b1 || attempts !== 33'd4 || nonce_out !== 32'h3) begin
            $display("FAIL restart got ok=%b e=%b att=%0d nonce=%h want 1/1/4/00000003", ok, exhausted, attempts, nonce_out);
            bad++;
        end
    endtask

    initial begin
        start       = 1'b0;
        reset       = 1'b0;
        header      = 96'h0011_2233_4455_6677_8899_AABB;
        nonce_start = '0;
        nonce_limit = '0;
        target      = '0;
        hash_done   = 1'b0;
        hash_out    = '0;
        @(posedge clk);
        #1;
        test_reset;
        test_find(8'h03, 32'hA4, 33'd165, 8'h01);
        test_find(8'h01, 32'hA5, 33'd166, 8'h00);
        test_exhaust;
        test_top_of_range;
        test_empty_range;
        test_timeout;
        test_reset_restart;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
